// File: rtl/otf_converter.sv
// On-the-fly MSDF signed-digit to two's-complement converter (Q/QM registers).
// Optional illegal-digit detection enabled by OTFC_ERR_CHECK_EN.
module otf_converter #(
   parameter int N = 8,
   localparam int W = N + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         digit_valid,
   input  logic [1:0]   zj,
   output logic         busy,
   output logic         done,
   output logic         result_valid,
   output logic [W-1:0] result,
   output logic         err
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [W-1:0]  r_q;
   logic [W-1:0]  r_qm;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic          r_rv;
   logic          w_clear;
   logic          w_accept;
   logic          w_last;
   logic          w_pos;
   logic          w_neg;

   // 2'b10 decodes as neither +1 nor -1, so it updates like a zero digit
   assign w_pos = (zj == 2'b01);
   assign w_neg = (zj == 2'b11);

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_CONV;
               w_clear     = 1'b1;
            end
         end
         S_CONV: begin
            if (start) begin
               w_clear = 1'b1;
            end else if (digit_valid) begin
               w_accept = 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_qm    <= '1;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_rv    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_last;
         if (w_clear) begin
            r_q   <= '0;
            r_qm  <= '1;
            r_cnt <= '0;
            r_rv  <= 1'b0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_rv <= 1'b1;
            if (w_pos) begin
               r_q  <= {r_q[W-2:0], 1'b1};
               r_qm <= {r_q[W-2:0], 1'b0};
            end else if (w_neg) begin
               r_q  <= {r_qm[W-2:0], 1'b1};
               r_qm <= {r_qm[W-2:0], 1'b0};
            end else begin
               r_q  <= {r_q[W-2:0], 1'b0};
               r_qm <= {r_qm[W-2:0], 1'b1};
            end
         end
      end
   end

`ifdef OTFC_ERR_CHECK_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_clear) begin
         r_err <= 1'b0;
      end else if (w_accept && (zj == 2'b10)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign busy         = (r_state == S_CONV);
   assign done         = r_done;
   assign result_valid = r_rv;
   assign result       = r_q;

endmodule

// File: tb/tb_otf_converter.sv
// Scoreboard bench for otf_converter: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_otf_converter;

   localparam int N = 8;
   localparam int W = N + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         digit_valid = 1'b0;
   logic [1:0]   zj = 2'b00;
   logic         busy;
   logic         done;
   logic         result_valid;
   logic [W-1:0] result;
   logic         err;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic prev_done = 1'b0;

   localparam logic [1:0] P = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam logic [1:0] M = 2'b11;
   localparam logic [1:0] X = 2'b10;

`ifdef OTFC_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   otf_converter #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .digit_valid  (digit_valid),
      .zj           (zj),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .result       (result),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && done) begin
         chk("done_single_pulse", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_result", 32'(result), 32'(e.res));
            chk("sb_err", 32'(err), 32'(e.err));
            chk("sb_result_valid", 32'(result_valid), 32'd1);
            chk("sb_busy", 32'(busy), 32'd0);
         end
      end
      prev_done = done;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] d);
      digit_valid = 1'b1;
      zj          = d;
      step();
      digit_valid = 1'b0;
      zj          = 2'b00;
   endtask

   task automatic send8(input logic [1:0] d[8]);
      for (int i = 0; i < 8; i++) send(d[i]);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic push(input logic [W-1:0] r, input logic e);
      exp_t x;
      x.res = r;
      x.err = e;
      sb.push_back(x);
   endtask

   initial begin
      logic [1:0] v[8];

      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      step();
      rst = 1'b1;
      step();

      // all +1 -> 255
      do_start();
      chk("busy_after_start", 32'(busy), 32'd1);
      push(9'h0FF, 1'b0);
      v = '{P, P, P, P, P, P, P, P};
      send8(v);
      drain();
      chk("hold_rv", 32'(result_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h0FF);
      chk("hold_done_low", 32'(done), 32'd0);

      // digit while DONE without start is ignored
      send(M);
      chk("done_ignore_result", 32'(result), 32'h0FF);
      chk("done_ignore_rv", 32'(result_valid), 32'd1);

      // all -1 -> -255
      do_start();
      chk("rv_cleared_by_start", 32'(result_valid), 32'd0);
      push(9'h101, 1'b0);
      v = '{M, M, M, M, M, M, M, M};
      send8(v);
      drain();

      // 128 - 127 = 1
      do_start();
      push(9'h001, 1'b0);
      v = '{P, M, M, M, M, M, M, M};
      send8(v);
      drain();

      // 64 - 8 + 1 = 57, with a 3-cycle gap after digit 2
      do_start();
      push(9'h039, 1'b0);
      send(Z);
      send(P);
      for (int i = 0; i < 3; i++) step();
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_rv", 32'(result_valid), 32'd0);
      chk("gap_partial_q", 32'(result), 32'h001);
      send(Z);
      send(Z);
      send(M);
      send(Z);
      send(Z);
      send(P);
      drain();

      // abort: 4 x +1, then start with a digit (dropped), then 8 zeros
      do_start();
      for (int i = 0; i < 4; i++) send(P);
      start       = 1'b1;
      digit_valid = 1'b1;
      zj          = P;
      step();
      start       = 1'b0;
      digit_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd1);
      chk("abort_q_cleared", 32'(result), 32'd0);
      push(9'h000, 1'b0);
      v = '{Z, Z, Z, Z, Z, Z, Z, Z};
      for (int i = 0; i < 7; i++) send(v[i]);
      chk("abort_no_early_rv", 32'(result_valid), 32'd0);
      send(v[7]);
      drain();

      // reset mid-conversion
      do_start();
      for (int i = 0; i < 5; i++) send(P);
      chk("pre_rst_partial", 32'(result), 32'h01F);
      rst = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_result", 32'(result), 32'd0);
      chk("async_rst_rv", 32'(result_valid), 32'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) send(P);
      step();
      chk("idle_ignore_rv", 32'(result_valid), 32'd0);
      chk("idle_ignore_busy", 32'(busy), 32'd0);
      chk("idle_ignore_result", 32'(result), 32'd0);

      // illegal digit in position 3
      do_start();
      push(9'h000, ERR_EXP);
      v = '{Z, Z, X, Z, Z, Z, Z, Z};
      send8(v);
      drain();
      chk("err_hold", 32'(err), 32'(ERR_EXP));
      do_start();
      chk("err_cleared_by_start", 32'(err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
